// File: rtl/piso_tx_if.sv
// Strobed serial link bundle between a frame requester (master) and piso_tx (slave).
interface piso_tx_if #(
  parameter int unsigned WIDTH = 10
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             tick;
  logic             sout;
  logic             bit_strobe;
  logic             busy;
  logic             done;

  modport master (
    output load, din, tick,
    input  sout, bit_strobe, busy, done
  );

  modport slave (
    input  load, din, tick,
    output sout, bit_strobe, busy, done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out frame transmitter: loads a WIDTH-bit word and shifts it out
// LSB-first, one bit per tick, on a strobed serial line.
// Optional feature macro: PISO_TX_PARITY_EN appends an odd-parity bit after the MSB.
module piso_tx #(
  parameter int unsigned WIDTH = 10
) (
  input logic       clk,
  input logic       rst,
  piso_tx_if.slave  tx_if
);

`ifdef PISO_TX_PARITY_EN
  localparam int unsigned Frame = WIDTH + 1;
`else
  localparam int unsigned Frame = WIDTH;
`endif
  localparam int unsigned     CntW    = $clog2(Frame + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Frame - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [Frame-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Frame-1:0]  load_word;

  // Word captured on an accepted load, parity bit sitting above the MSB when enabled.
`ifdef PISO_TX_PARITY_EN
  assign load_word = {~^tx_if.din, tx_if.din};
`else
  assign load_word = tx_if.din;
`endif

  // State, shift register and bit counter; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load only accepted in idle (a coincident tick is discarded), shift on tick.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (tx_if.load) begin
          sreg_d  = load_word;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (tx_if.tick) begin
          sreg_d = {1'b0, sreg_q[Frame-1:1]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state; only bit_strobe passes tick through combinationally.
  always_comb begin
    tx_if.sout       = 1'b0;
    tx_if.busy       = 1'b0;
    tx_if.done       = 1'b0;
    tx_if.bit_strobe = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StShift: begin
        tx_if.sout       = sreg_q[0];
        tx_if.busy       = 1'b1;
        tx_if.bit_strobe = tx_if.tick;
      end
      StDone: begin
        tx_if.busy = 1'b1;
        tx_if.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: randomized frames against a frame-level reference model
// and a shift-right receiver fed by sout/bit_strobe.
module tb_piso_tx;
  localparam int unsigned W = 10;
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned FRAME = W + 1;
`else
  localparam int unsigned FRAME = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  piso_tx_if #(.WIDTH(W)) bus ();

  piso_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (bus)
  );

  always #5 clk = ~clk;

  // Receiving end of the link: WIDTH(+parity)-bit shift-right register.
  logic [FRAME-1:0] rx_q;
  always @(posedge clk or posedge rst) begin
    if (rst) rx_q <= '0;
    else if (bus.bit_strobe) rx_q <= {bus.sout, rx_q[FRAME-1:1]};
  end

  // Reference: the frame is the word LSB-first, optionally followed by its odd parity.
  function automatic logic [FRAME-1:0] model_frame(input logic [W-1:0] d);
`ifdef PISO_TX_PARITY_EN
    return {~^d, d};
`else
    return d;
`endif
  endfunction

  // One clock: drive inputs at the falling edge, let combinational outputs settle.
  task automatic cycle(input logic l, input logic [W-1:0] d, input logic t);
    @(negedge clk);
    bus.load = l;
    bus.din  = d;
    bus.tick = t;
    #1;
  endtask

  // Send one frame and collect what the line carried.
  task automatic xmit(input logic [W-1:0] d, input int per, input bit tick_at_load,
                      input bit spam, output logic [FRAME-1:0] bits, output int nstrobe,
                      output int nbusy, output int ndone, output int done_cyc,
                      output logic [FRAME-1:0] rx_done, output bit tout);
    int c;
    bit fin;
    bits = '0; nstrobe = 0; nbusy = 0; ndone = 0; done_cyc = -1; rx_done = '0;
    fin = 1'b0;
    c = 1;
    cycle(1'b1, d, tick_at_load);
    while (!fin && c < 300) begin
      if (spam && c >= 2 && c <= 5) cycle(1'b1, 10'h3FF, (c % per) == 0);
      else cycle(1'b0, W'($urandom), (c % per) == 0);
      if (bus.bit_strobe) begin
        if (nstrobe < FRAME) bits[nstrobe] = bus.sout;
        nstrobe++;
      end
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        done_cyc = c;
        rx_done  = rx_q;
      end else if (ndone > 0) begin
        fin = 1'b1;
      end
      c++;
    end
    tout = !fin;
    bus.load = 1'b0;
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] o;
    bus.load = 1'b0; bus.din = '0; bus.tick = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    o = {bus.sout, bus.busy, bus.done, bus.bit_strobe};
    n_checks++;
    if (o !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000", o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, W'($urandom), 1'($urandom));
      o = {bus.sout, bus.busy, bus.done, bus.bit_strobe};
      n_checks++;
      if (o !== 4'b0) begin
        n_fail++;
        $display("FAIL idle_outputs cycle %0d: got %b required 0000", i, o);
      end
    end
  endtask

  task automatic test_basic();
    logic [FRAME-1:0] bits, rx;
    int ns, nb, nd, dc;
    bit to;
    xmit(10'h2CE, 1, 1'b0, 1'b0, bits, ns, nb, nd, dc, rx, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: frame never completed"); end
    n_checks++;
    if (bits !== model_frame(10'h2CE)) begin
      n_fail++; $display("FAIL basic_bits: got %h required %h", bits, model_frame(10'h2CE));
    end
    n_checks++;
    if (ns != FRAME) begin n_fail++; $display("FAIL basic_strobes: got %0d required %0d", ns, FRAME); end
    n_checks++;
    if (nd != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses required 1", nd); end
    n_checks++;
    if (nb != FRAME + 1) begin n_fail++; $display("FAIL basic_busy: got %0d required %0d", nb, FRAME + 1); end
    n_checks++;
    if (dc != FRAME + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required %0d", dc, FRAME + 1); end
  endtask

  task automatic test_loopback();
    logic [FRAME-1:0] bits, rx;
    int ns, nb, nd, dc;
    bit to;
    xmit(10'h155, 4, 1'b0, 1'b0, bits, ns, nb, nd, dc, rx, to);
    n_checks++;
    if (to || nd != 1) begin n_fail++; $display("FAIL loop_done: got %0d pulses timeout=%0d required 1", nd, to); end
    n_checks++;
    if (rx !== model_frame(10'h155)) begin
      n_fail++; $display("FAIL loop_rx: got %h required %h", rx, model_frame(10'h155));
    end
  endtask

  task automatic test_ignored();
    logic [FRAME-1:0] bits, rx;
    int ns, nb, nd, dc;
    bit to;
    // tick coincides with load in idle, and loads of 3FF arrive during shifting
    xmit(10'h2CE, 2, 1'b1, 1'b1, bits, ns, nb, nd, dc, rx, to);
    n_checks++;
    if (bits !== model_frame(10'h2CE) || ns != FRAME) begin
      n_fail++; $display("FAIL ignored_bits: got %h (%0d strobes) required %h", bits, ns, model_frame(10'h2CE));
    end
    n_checks++;
    if (rx !== model_frame(10'h2CE) || nd != 1) begin
      n_fail++; $display("FAIL ignored_rx: got %h done=%0d required %h", rx, nd, model_frame(10'h2CE));
    end
    // line must be idle afterwards: no queued frame
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.bit_strobe !== 1'b0) begin
      n_fail++; $display("FAIL ignored_noqueue: busy=%b strobe=%b required 0 0", bus.busy, bus.bit_strobe);
    end
  endtask

  task automatic test_abort();
    logic [FRAME-1:0] bits, rx;
    logic [3:0] o;
    int ns, nb, nd, dc, n;
    bit to, seen_done;
    n = 0;
    cycle(1'b1, 10'h2CE, 1'b0);
    for (int i = 0; i < 20 && n < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (bus.bit_strobe) n++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    o = {bus.sout, bus.busy, bus.done, bus.bit_strobe};
    n_checks++;
    if (n != 4 || o !== 4'b0) begin
      n_fail++; $display("FAIL abort_outputs: got %b after %0d strobes required 0000", o, n);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (bus.done !== 1'b0) seen_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin n_fail++; $display("FAIL abort_nodone: got done/busy after abort required none"); end
    xmit(10'h0A5, 1, 1'b0, 1'b0, bits, ns, nb, nd, dc, rx, to);
    n_checks++;
    if (bits !== model_frame(10'h0A5) || rx !== model_frame(10'h0A5) || nd != 1) begin
      n_fail++; $display("FAIL abort_next: got %h rx %h done=%0d required %h", bits, rx, nd, model_frame(10'h0A5));
    end
  endtask

  task automatic test_random();
    logic [FRAME-1:0] bits, rx, exp;
    logic [W-1:0] d;
    int ns, nb, nd, dc, per;
    bit to, tal;
    for (int i = 0; i < 8; i++) begin
      d   = W'($urandom);
      per = $urandom_range(1, 4);
      tal = 1'($urandom_range(0, 1));
      exp = model_frame(d);
      xmit(d, per, tal, 1'b0, bits, ns, nb, nd, dc, rx, to);
      n_checks++;
      if (to || bits !== exp || ns != FRAME || nd != 1) begin
        n_fail++;
        $display("FAIL random_%0d: got bits %h strobes %0d done %0d required %h %0d 1 (per %0d)",
                 i, bits, ns, nd, exp, FRAME, per);
      end
      n_checks++;
      if (rx !== exp) begin n_fail++; $display("FAIL random_rx_%0d: got %h required %h", i, rx, exp); end
    end
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    logic [FRAME-1:0] bits, rx;
    int ns, nb, nd, dc;
    bit to;
    xmit(10'h2CE, 1, 1'b0, 1'b0, bits, ns, nb, nd, dc, rx, to);
    n_checks++;
    if (ns != 11 || bits[10] !== 1'b1) begin
      n_fail++; $display("FAIL parity_2CE: got %0d strobes bit10=%b required 11 1", ns, bits[10]);
    end
    xmit(10'h2CF, 1, 1'b0, 1'b0, bits, ns, nb, nd, dc, rx, to);
    n_checks++;
    if (ns != 11 || bits[10] !== 1'b0) begin
      n_fail++; $display("FAIL parity_2CF: got %0d strobes bit10=%b required 11 0", ns, bits[10]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_ignored();
    test_abort();
    test_random();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out frame transmitter. It loads a WIDTH-bit word and shifts it out LSB-first, one bit per `tick` strobe, on a single serial line. It is the sending end of the team's strobed serial shift-register link. It drives the link's data line (`sout`) and shift strobe (`bit_strobe`) so that a matching WIDTH-bit shift-right receiver holds exactly `din` after one frame.

## Interface
- WIDTH, 10, data bits per frame (minimum 2)
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- load  in  1  frame request; sampled only in IDLE
- din  in  WIDTH  parallel word; captured on the accepted `load` edge
- tick  in  1  bit-rate enable, one clk cycle wide (debounced pulse or divider output)
- sout  out  1  serial data; current bit, held stable between strobes
- bit_strobe  out  1  shift strobe for the receiver; combinational `tick & (state==SHIFT)`
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse marking frame completion

## Operation
- States:
  - IDLE: `sout`=0, `busy`=0, `done`=0.
    - `load`=1 captures `din` into shift register `sreg`, clears bit counter `cnt`, goes to SHIFT.
  - SHIFT: `sout`=`sreg[0]`; `bit_strobe`=`tick`.
    - On a `tick` edge: `sreg` shifts right with 0 fill, `cnt`+1.
    - On the `tick` edge with `cnt`==FRAME-1: go to DONE.
  - DONE: lasts one cycle; `done`=1, `busy`=1, `sout`=0, `bit_strobe`=0; next state IDLE.
- FRAME = WIDTH, or WIDTH+1 with parity (see Configuration).
- `cnt` width is ceil(log2(FRAME+1)) bits. `cnt` never wraps; it is cleared on load.
- `load` in SHIFT or DONE: ignored, no queueing. `din` changes after capture: no effect.
- `tick` in IDLE or DONE: no effect; `bit_strobe` stays 0.
- `load` and `tick` in the same IDLE cycle: load accepted, tick discarded. The first bit is not consumed.
- Reset values: state IDLE, `sreg`=0, `cnt`=0. Outputs `sout`=0, `busy`=0, `done`=0, `bit_strobe`=0.
- Reset mid-frame: the frame is aborted immediately (asynchronous); no `done` pulse is issued.

## Timing
- `load` accepted at edge E: `busy`=1 and `sout`=`din[0]` from E+ onward.
- Bit k is on `sout` from the k-th strobe edge until the (k+1)-th strobe edge. The receiver samples bit k on the edge where `bit_strobe`=1.
- With `tick` held high continuously:
  - strobe edges are E+1 … E+FRAME;
  - `done`=1 in the cycle following edge E+FRAME;
  - IDLE is reached at edge E+FRAME+1.
- Earliest next accepted `load`: edge E+FRAME+2.
- `busy` falls together with `done` falling.
- `sout`, `busy` and `done` are registered or state-decoded and glitch-free. `bit_strobe` is combinational from `tick`.

## Configuration
- Macro `PISO_TX_PARITY_EN`.
- Defined:
  - an odd-parity bit (`~^din`) is captured at load and sent after `din[WIDTH-1]`;
  - FRAME = WIDTH+1;
  - the receiver must be WIDTH+1 bits wide;
  - `sreg` is WIDTH+1 bits.
- Undefined: no parity bit; FRAME = WIDTH; `sreg` is WIDTH bits.

## Test plan
- Reset, then idle: `rst` pulse, `tick` toggling, no `load` -> `sout`=0, `busy`=0, `done`=0, `bit_strobe`=0 throughout.
- Basic frame: `din`=10'h2CE, `load` 1 cycle, `tick` held high -> `sout` sequence 0,1,1,1,0,0,1,1,0,1. Exactly 10 `bit_strobe` cycles, then `done` high 1 cycle, `busy` high for 11 cycles.
- Loopback: `sout`->push and `bit_strobe`->pulse_out into a 10-bit shift-right receiver, `tick` every 4th cycle, `din`=10'h155 -> receiver Q=10'h155 when `done` pulses.
- Ignored requests: second `load` with `din`=10'h3FF during SHIFT; `load`+`tick` in the same IDLE cycle -> frame still 10'h2CE, and the first bit is not skipped.
- Abort: `rst` asserted after the 4th strobe of 10'h2CE -> all outputs 0 immediately, no `done`. A new load of 10'h0A5 then transmits correctly.
- Parity (`PISO_TX_PARITY_EN` defined): `din`=10'h2CE -> 11 strobes, bit 10 = 1. `din`=10'h2CF -> bit 10 = 0.
